// File: rtl/camera_pkg.sv
// Shared types for the camera capture front end.
package camera_pkg;

    localparam int COORD_W   = 16;
    localparam int MAX_BEATS = 2;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        DECIM_1,
        DECIM_2,
        DECIM_4,
        DECIM_8
    } decim_e;

    typedef enum logic {
        WAIT_FRAME,
        IN_FRAME
    } capture_state_e;

endpackage

// File: rtl/camera_sync_edge.sv
// Sensor bus input register, polarity normalisation and href/vsync edges.
module camera_sync_edge #(
    parameter int BUS_WIDTH         = 8,
    parameter bit VSYNC_ACTIVE_HIGH = 1'b1,
    parameter bit HREF_ACTIVE_HIGH  = 1'b1
) (
    input  logic                 pixclk_i,
    input  logic                 reset_n_i,
    input  logic [BUS_WIDTH-1:0] pixel_data_i,
    input  logic                 href_i,
    input  logic                 vsync_i,
    output logic [BUS_WIDTH-1:0] data,
    output logic                 line_act,
    output logic                 line_fall,
    output logic                 frame_start,
    output logic                 frame_end
);

    logic act0_q, act1_q;
    logic blank0_q, blank1_q;

    always_ff @(posedge pixclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data     <= '0;
            act0_q   <= 1'b0;
            act1_q   <= 1'b0;
            blank0_q <= 1'b0;
            blank1_q <= 1'b0;
        end else begin
            data     <= pixel_data_i;
            act0_q   <= href_i ~^ HREF_ACTIVE_HIGH;
            blank0_q <= vsync_i ~^ VSYNC_ACTIVE_HIGH;
            act1_q   <= act0_q;
            blank1_q <= blank0_q;
        end
    end

    assign line_act    = act0_q;
    assign line_fall   = act1_q & ~act0_q;
    assign frame_start = blank1_q & ~blank0_q;
    assign frame_end   = ~blank1_q & blank0_q;

endmodule

// File: rtl/camera_window_capture.sv
// Camera capture front end: pixel assembly, crop window, decimation
// and frame markers, all on pixclk_i.
module camera_window_capture #(
    parameter int BUS_WIDTH         = 8,
    parameter int BEATS_PER_PIXEL   = 1,
    parameter int COORD_WIDTH       = 16,
    parameter bit VSYNC_ACTIVE_HIGH = 1'b1,
    parameter bit HREF_ACTIVE_HIGH  = 1'b1
) (
    input  logic                                 pixclk_i,
    input  logic                                 reset_n_i,
    input  logic [BUS_WIDTH-1:0]                 pixel_data_i,
    input  logic                                 href_i,
    input  logic                                 vsync_i,
    input  logic [COORD_WIDTH-1:0]               win_x_i,
    input  logic [COORD_WIDTH-1:0]               win_y_i,
    input  logic [COORD_WIDTH-1:0]               win_w_i,
    input  logic [COORD_WIDTH-1:0]               win_h_i,
    input  logic [1:0]                           decim_i,
    output logic                                 pix_valid_o,
    output logic [BUS_WIDTH*BEATS_PER_PIXEL-1:0] pix_o,
    output logic [COORD_WIDTH-1:0]               row_o,
    output logic [COORD_WIDTH-1:0]               col_o,
    output logic                                 sof_o,
    output logic                                 eol_o,
    output logic                                 eof_o,
    output logic [COORD_WIDTH-1:0]               frame_cnt_o,
    output logic                                 beat_err_o,
    output logic                                 trunc_err_o
);

    import camera_pkg::*;

    localparam int PIX_W  = BUS_WIDTH * BEATS_PER_PIXEL;
    localparam int BEAT_W = $clog2(MAX_BEATS);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS_PER_PIXEL - 1);

    typedef logic [COORD_WIDTH-1:0] crd_t;

    function automatic crd_t sat_inc(input crd_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [BUS_WIDTH-1:0] s_data;
    logic s_act, s_fall, s_start, s_end;

    camera_sync_edge #(
        .BUS_WIDTH        (BUS_WIDTH),
        .VSYNC_ACTIVE_HIGH(VSYNC_ACTIVE_HIGH),
        .HREF_ACTIVE_HIGH (HREF_ACTIVE_HIGH)
    ) u_sync (
        .pixclk_i    (pixclk_i),
        .reset_n_i   (reset_n_i),
        .pixel_data_i(pixel_data_i),
        .href_i      (href_i),
        .vsync_i     (vsync_i),
        .data        (s_data),
        .line_act    (s_act),
        .line_fall   (s_fall),
        .frame_start (s_start),
        .frame_end   (s_end)
    );

    capture_state_e state_q, state_d;
    logic start, take, line_end, stop;

    crd_t wx_q, wy_q, ww_q, wh_q;
    decim_e dec_q;
    crd_t row_q, col_q, row_cur, col_cur;
    logic [BEAT_W-1:0] beat_q, beat_cur;
    logic done;

    logic cp_valid_q;
    crd_t cp_col_q, cp_row_q;
    logic [PIX_W-1:0] cp_pix_q, assembled;

    crd_t rel_c, rel_r, mask, out_c, out_r;
    logic in_x, in_y, emit, emit_eol, emit_eof;
    logic eof_seen_q;

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        take     = 1'b0;
        line_end = 1'b0;
        stop     = 1'b0;
        unique case (state_q)
            WAIT_FRAME: begin
                if (s_start) begin
                    state_d = IN_FRAME;
                    start   = 1'b1;
                    take    = s_act;
                end
            end
            IN_FRAME: begin
                if (s_end) begin
                    state_d = WAIT_FRAME;
                    stop    = 1'b1;
                end else begin
                    take     = s_act;
                    line_end = s_fall;
                end
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    // A beat arriving with the frame-start edge sees zeroed counters.
    assign col_cur  = start ? '0 : col_q;
    assign row_cur  = start ? '0 : row_q;
    assign beat_cur = start ? '0 : beat_q;
    assign done     = take && (beat_cur == BEAT_LAST);

    if (BEATS_PER_PIXEL == 2) begin : g_two
        logic [BUS_WIDTH-1:0] hold_q;
        always_ff @(posedge pixclk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                hold_q <= '0;
            end else if (take && !done) begin
                hold_q <= s_data;
            end
        end
        assign assembled = {hold_q, s_data};
    end else begin : g_one
        assign assembled = s_data;
    end

    always_ff @(posedge pixclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= WAIT_FRAME;
            wx_q        <= '0;
            wy_q        <= '0;
            ww_q        <= '0;
            wh_q        <= '0;
            dec_q       <= DECIM_1;
            frame_cnt_o <= '0;
            row_q       <= '0;
            col_q       <= '0;
            beat_q      <= '0;
            cp_valid_q  <= 1'b0;
            cp_col_q    <= '0;
            cp_row_q    <= '0;
            cp_pix_q    <= '0;
            beat_err_o  <= 1'b0;
            trunc_err_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cp_valid_q  <= done;
            beat_err_o  <= line_end && (beat_q != '0);
            trunc_err_o <= stop && (ww_q != '0) && (wh_q != '0)
                           && !(eof_seen_q || emit_eof);
            if (start) begin
                wx_q        <= win_x_i;
                wy_q        <= win_y_i;
                ww_q        <= win_w_i;
                wh_q        <= win_h_i;
                dec_q       <= decim_e'(decim_i);
                frame_cnt_o <= frame_cnt_o + 1'b1;
                row_q       <= '0;
                col_q       <= '0;
                beat_q      <= '0;
            end
            if (take) begin
                beat_q <= done ? '0 : beat_cur + 1'b1;
                if (done) begin
                    col_q <= sat_inc(col_cur);
                end
            end else if (line_end) begin
                row_q  <= sat_inc(row_q);
                col_q  <= '0;
                beat_q <= '0;
            end
            if (done) begin
                cp_col_q <= col_cur;
                cp_row_q <= row_cur;
                cp_pix_q <= assembled;
            end
        end
    end

    // Window ends are compared one bit wider so they cannot wrap.
    always_comb begin
        rel_c = cp_col_q - wx_q;
        rel_r = cp_row_q - wy_q;
        mask  = ~({COORD_WIDTH{1'b1}} << dec_q);
        in_x  = (cp_col_q >= wx_q)
                && ({1'b0, cp_col_q} < ({1'b0, wx_q} + {1'b0, ww_q}));
        in_y  = (cp_row_q >= wy_q)
                && ({1'b0, cp_row_q} < ({1'b0, wy_q} + {1'b0, wh_q}));
        emit  = cp_valid_q && in_x && in_y
                && ((rel_c & mask) == '0) && ((rel_r & mask) == '0);
        out_c = rel_c >> dec_q;
        out_r = rel_r >> dec_q;
        emit_eol = emit && (out_c == ((ww_q - 1'b1) >> dec_q));
        emit_eof = emit_eol && (out_r == ((wh_q - 1'b1) >> dec_q));
    end

    always_ff @(posedge pixclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pix_valid_o <= 1'b0;
            pix_o       <= '0;
            row_o       <= '0;
            col_o       <= '0;
            sof_o       <= 1'b0;
            eol_o       <= 1'b0;
            eof_o       <= 1'b0;
            eof_seen_q  <= 1'b0;
        end else begin
            pix_valid_o <= emit;
            sof_o       <= emit && (rel_c == '0) && (rel_r == '0);
            eol_o       <= emit_eol;
            eof_o       <= emit_eof;
            if (emit) begin
                pix_o <= cp_pix_q;
                col_o <= out_c;
                row_o <= out_r;
            end
            if (start) begin
                eof_seen_q <= 1'b0;
            end else if (emit_eof) begin
                eof_seen_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_camera_window_capture.sv
// Scoreboard bench for camera_window_capture: 1-beat and 2-beat instances
// share one sensor stream; each has its own expected-pixel queue.
module tb_camera_window_capture;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [7:0] data = '0;
    logic href = 1'b0;
    logic vsync = 1'b1;
    logic [15:0] win_x = '0, win_y = '0, win_w = '0, win_h = '0;
    logic [1:0] decim = '0;

    logic v1, sof1, eol1, eof1, be1, tr1;
    logic [7:0] p1;
    logic [15:0] r1, c1, fc1;
    logic v2, sof2, eol2, eof2, be2, tr2;
    logic [15:0] p2;
    logic [15:0] r2, c2, fc2;

    always #5 clk = ~clk;

    camera_window_capture dut (
        .pixclk_i(clk), .reset_n_i(rst_n), .pixel_data_i(data),
        .href_i(href), .vsync_i(vsync),
        .win_x_i(win_x), .win_y_i(win_y), .win_w_i(win_w), .win_h_i(win_h),
        .decim_i(decim),
        .pix_valid_o(v1), .pix_o(p1), .row_o(r1), .col_o(c1),
        .sof_o(sof1), .eol_o(eol1), .eof_o(eof1), .frame_cnt_o(fc1),
        .beat_err_o(be1), .trunc_err_o(tr1)
    );

    camera_window_capture #(.BEATS_PER_PIXEL(2)) dut2 (
        .pixclk_i(clk), .reset_n_i(rst_n), .pixel_data_i(data),
        .href_i(href), .vsync_i(vsync),
        .win_x_i(win_x), .win_y_i(win_y), .win_w_i(win_w), .win_h_i(win_h),
        .decim_i(decim),
        .pix_valid_o(v2), .pix_o(p2), .row_o(r2), .col_o(c2),
        .sof_o(sof2), .eol_o(eol2), .eof_o(eof2), .frame_cnt_o(fc2),
        .beat_err_o(be2), .trunc_err_o(tr2)
    );

    typedef struct {
        logic [15:0] pix;
        logic [15:0] row;
        logic [15:0] col;
        logic sof, eol, eof;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int checks = 0;
    int errors = 0;
    bit mon1_en = 1'b0;
    bit mon2_en = 1'b0;
    int v1_cnt = 0, tr1_cnt = 0, be2_cnt = 0, tr2_cnt = 0;
    logic v2_prev = 1'b0;

    always @(negedge clk) begin
        if (v1) v1_cnt++;
        if (tr1) tr1_cnt++;
        if (mon1_en && v1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL mon1_unexpected pix=%h row=%0d col=%0d", p1, r1, c1);
            end else begin
                e1 = q1.pop_front();
                if ({8'h00, p1, r1, c1, sof1, eol1, eof1} !==
                    {e1.pix, e1.row, e1.col, e1.sof, e1.eol, e1.eof}) begin
                    errors++;
                    $display("FAIL mon1_pixel got pix=%h r=%0d c=%0d s/l/f=%b%b%b want pix=%h r=%0d c=%0d s/l/f=%b%b%b",
                             p1, r1, c1, sof1, eol1, eof1,
                             e1.pix, e1.row, e1.col, e1.sof, e1.eol, e1.eof);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (be2) be2_cnt++;
        if (tr2) tr2_cnt++;
        if (mon2_en && v2) begin
            checks++;
            if (v2_prev !== 1'b0) begin
                errors++;
                $display("FAIL mon2_back_to_back valid high on consecutive cycles");
            end
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL mon2_unexpected pix=%h row=%0d col=%0d", p2, r2, c2);
            end else begin
                e2 = q2.pop_front();
                if ({p2, r2, c2, sof2, eol2, eof2} !==
                    {e2.pix, e2.row, e2.col, e2.sof, e2.eol, e2.eof}) begin
                    errors++;
                    $display("FAIL mon2_pixel got pix=%h r=%0d c=%0d s/l/f=%b%b%b want pix=%h r=%0d c=%0d s/l/f=%b%b%b",
                             p2, r2, c2, sof2, eol2, eof2,
                             e2.pix, e2.row, e2.col, e2.sof, e2.eol, e2.eof);
                end
            end
        end
        v2_prev = v2;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    function automatic logic [7:0] pix_of(input int r, input int c);
        int v;
        v = r * 16 + c;
        return v[7:0] ^ 8'h5A;
    endfunction

    task automatic model_push(input int c, input int r, input int wx, input int wy,
                              input int ww, input int wh, input int dec,
                              input logic [7:0] d);
        int s;
        exp_t e;
        s = 1 << dec;
        if (ww > 0 && wh > 0 && c >= wx && c < wx + ww && r >= wy && r < wy + wh
            && (c - wx) % s == 0 && (r - wy) % s == 0) begin
            e.pix = {8'h00, d};
            e.col = 16'((c - wx) / s);
            e.row = 16'((r - wy) / s);
            e.sof = (c == wx) && (r == wy);
            e.eol = (c - wx + s) >= ww;
            e.eof = e.eol && ((r - wy + s) >= wh);
            q1.push_back(e);
        end
    endtask

    task automatic run_frame(input int w, input int rows, input int wx, input int wy,
                             input int ww, input int wh, input int dec, input int mid_wx);
        win_x = 16'(wx);
        win_y = 16'(wy);
        win_w = 16'(ww);
        win_h = 16'(wh);
        decim = 2'(dec);
        vsync = 1'b1;
        idle(3);
        vsync = 1'b0;
        idle(3);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < w; c++) begin
                href = 1'b1;
                data = pix_of(r, c);
                model_push(c, r, wx, wy, ww, wh, dec, data);
                step();
            end
            href = 1'b0;
            data = '0;
            if (r == 0) win_x = 16'(mid_wx);
            idle(3);
        end
        vsync = 1'b1;
        idle(6);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({v1, p1, r1, c1, sof1, eol1, eof1, fc1, be1, tr1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1 outputs=%h want 0",
                     {v1, p1, r1, c1, sof1, eol1, eof1, fc1, be1, tr1});
        end
        checks++;
        if ({v2, p2, r2, c2, sof2, eol2, eof2, fc2, be2, tr2} !== '0) begin
            errors++;
            $display("FAIL reset_dut2 outputs=%h want 0",
                     {v2, p2, r2, c2, sof2, eol2, eof2, fc2, be2, tr2});
        end
        rst_n = 1'b1;
        idle(4);
        checks++;
        if (fc1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_idle_frame_cnt got %0d want 0", fc1);
        end
    endtask

    task automatic test_window_basic();
        int t0;
        mon1_en = 1'b1;
        t0 = tr1_cnt;
        run_frame(6, 4, 1, 1, 4, 2, 0, 1);
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL basic_drain got %0d left want 0", q1.size());
        end
        checks++;
        if (fc1 !== 16'd1) begin
            errors++;
            $display("FAIL basic_frame_cnt got %0d want 1", fc1);
        end
        checks++;
        if (tr1_cnt != t0) begin
            errors++;
            $display("FAIL basic_no_trunc got %0d pulses want 0", tr1_cnt - t0);
        end
    endtask

    task automatic test_decimation();
        run_frame(16, 8, 0, 0, 16, 8, 2, 0);
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL decim_drain got %0d left want 0", q1.size());
        end
    endtask

    task automatic test_two_beat();
        int b0, t0;
        exp_t e;
        logic [7:0] beats[5];
        beats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        mon1_en = 1'b0;
        mon2_en = 1'b1;
        b0 = be2_cnt;
        t0 = tr2_cnt;
        win_x = 16'd0; win_y = 16'd0; win_w = 16'd2; win_h = 16'd2; decim = 2'd0;
        vsync = 1'b1;
        idle(3);
        vsync = 1'b0;
        idle(3);
        e = '{pix: 16'hABCD, row: 16'd0, col: 16'd0, sof: 1'b1, eol: 1'b0, eof: 1'b0};
        q2.push_back(e);
        href = 1'b1;
        data = 8'hAB;
        step();
        data = 8'hCD;
        step();
        href = 1'b0;
        data = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (v2 !== 1'b0) begin
            errors++;
            $display("FAIL twobeat_early valid=%b want 0 one cycle after sample", v2);
        end
        @(negedge clk);
        checks++;
        if ({v2, p2} !== {1'b1, 16'hABCD}) begin
            errors++;
            $display("FAIL twobeat_latency valid=%b pix=%h want 1 abcd", v2, p2);
        end
        step();
        idle(2);
        e = '{pix: 16'h1122, row: 16'd1, col: 16'd0, sof: 1'b0, eol: 1'b0, eof: 1'b0};
        q2.push_back(e);
        e = '{pix: 16'h3344, row: 16'd1, col: 16'd1, sof: 1'b0, eol: 1'b1, eof: 1'b1};
        q2.push_back(e);
        for (int i = 0; i < 5; i++) begin
            href = 1'b1;
            data = beats[i];
            step();
        end
        href = 1'b0;
        data = '0;
        idle(4);
        vsync = 1'b1;
        idle(6);
        checks++;
        if (be2_cnt != b0 + 1) begin
            errors++;
            $display("FAIL twobeat_beat_err got %0d pulses want 1", be2_cnt - b0);
        end
        checks++;
        if (tr2_cnt != t0) begin
            errors++;
            $display("FAIL twobeat_no_trunc got %0d pulses want 0", tr2_cnt - t0);
        end
        checks++;
        if (q2.size() != 0) begin
            errors++;
            $display("FAIL twobeat_drain got %0d left want 0", q2.size());
        end
        mon2_en = 1'b0;
        idle(2);
        mon1_en = 1'b1;
    endtask

    task automatic test_window_change();
        logic [15:0] f0;
        f0 = fc1;
        run_frame(6, 3, 0, 0, 4, 2, 0, 2);
        checks++;
        if (fc1 !== f0 + 16'd1) begin
            errors++;
            $display("FAIL winchg_cnt_a got %0d want %0d", fc1, f0 + 16'd1);
        end
        run_frame(6, 3, 2, 0, 4, 2, 0, 2);
        checks++;
        if (fc1 !== f0 + 16'd2) begin
            errors++;
            $display("FAIL winchg_cnt_b got %0d want %0d", fc1, f0 + 16'd2);
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL winchg_drain got %0d left want 0", q1.size());
        end
    endtask

    task automatic test_truncation();
        int t0;
        t0 = tr1_cnt;
        run_frame(6, 1, 0, 0, 4, 4, 0, 0);
        checks++;
        if (tr1_cnt != t0 + 1) begin
            errors++;
            $display("FAIL trunc_pulse got %0d pulses want 1", tr1_cnt - t0);
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL trunc_drain got %0d left want 0", q1.size());
        end
    endtask

    task automatic test_reset_midline();
        int v0;
        win_x = 16'd0; win_y = 16'd1; win_w = 16'd4; win_h = 16'd2; decim = 2'd0;
        vsync = 1'b1;
        idle(3);
        vsync = 1'b0;
        idle(3);
        for (int c = 0; c < 3; c++) begin
            href = 1'b1;
            data = pix_of(0, c);
            step();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({v1, p1, r1, c1, sof1, eol1, eof1, fc1, be1, tr1} !== '0) begin
            errors++;
            $display("FAIL midreset_async outputs=%h want 0",
                     {v1, p1, r1, c1, sof1, eol1, eof1, fc1, be1, tr1});
        end
        v0 = v1_cnt;
        step();
        step();
        rst_n = 1'b1;
        idle(2);
        href = 1'b0;
        idle(3);
        for (int r = 1; r < 3; r++) begin
            for (int c = 0; c < 6; c++) begin
                href = 1'b1;
                data = pix_of(r, c);
                step();
            end
            href = 1'b0;
            idle(3);
        end
        vsync = 1'b1;
        idle(6);
        checks++;
        if (v1_cnt != v0) begin
            errors++;
            $display("FAIL midreset_quiet got %0d pixels want 0", v1_cnt - v0);
        end
        checks++;
        if (fc1 !== 16'd0) begin
            errors++;
            $display("FAIL midreset_frame_cnt got %0d want 0", fc1);
        end
        run_frame(6, 4, 1, 1, 4, 2, 0, 1);
        checks++;
        if (fc1 !== 16'd1) begin
            errors++;
            $display("FAIL midreset_resume_cnt got %0d want 1", fc1);
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL midreset_drain got %0d left want 0", q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_window_basic();
        test_decimation();
        test_two_beat();
        test_window_change();
        test_truncation();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/camera_window_capture.md
Name: camera_window_capture

Overview:
Next-generation image-sensor capture front end: samples a parallel camera bus (pixel data, href, vsync) and assembles 1- or 2-beat pixels, e.g. RGB565 over 8 bits. Applies a runtime-programmable crop window and power-of-two decimation. Emits pixels with window-relative coordinates plus frame/line markers on the generic camera data interface. Runs entirely on pixclk_i; downstream CDC/FIFO is out of scope.

Parameters:
BUS_WIDTH, 8, sensor data bus width in bits
BEATS_PER_PIXEL, 1, bus beats per pixel; legal values 1 or 2
COORD_WIDTH, 16, width of all row/column counters and window inputs
VSYNC_ACTIVE_HIGH, 1, 1: vsync high = blanking; 0: inverted
HREF_ACTIVE_HIGH, 1, 1: href high = valid data; 0: inverted

Ports:
pixclk_i  in  1  sensor pixel clock; sole clock
reset_n_i  in  1  asynchronous active-low reset
pixel_data_i  in  BUS_WIDTH  sensor data bus
href_i  in  1  line-valid strobe
vsync_i  in  1  frame sync
win_x_i  in  COORD_WIDTH  crop start column, in pixels
win_y_i  in  COORD_WIDTH  crop start row
win_w_i  in  COORD_WIDTH  crop width; 0 = no output
win_h_i  in  COORD_WIDTH  crop height; 0 = no output
decim_i  in  2  0:1/1 1:1/2 2:1/4 3:1/8, both axes
pix_valid_o  out  1  output pixel valid, one-cycle qualifier
pix_o  out  BUS_WIDTH*BEATS_PER_PIXEL  assembled pixel; first beat in MSBs
row_o  out  COORD_WIDTH  decimated window-relative row
col_o  out  COORD_WIDTH  decimated window-relative column
sof_o  out  1  high with pixel (0,0)
eol_o  out  1  high with last emitted pixel of a row
eof_o  out  1  high with last emitted pixel of the frame
frame_cnt_o  out  COORD_WIDTH  frames started since reset, wraps
beat_err_o  out  1  1-cycle pulse: line ended with a partial pixel
trunc_err_o  out  1  1-cycle pulse: vsync reasserted before the window completed

Behaviour:
- Reset (asynchronous, reset_n_i low) clears every output, counter and register to 0; state = WAIT_FRAME.
- Stage 0: data, href and vsync are registered, and href/vsync are normalised to active/blank per the polarity params.
- Stage 1: a delayed copy is held for edge detection.
- FSM WAIT_FRAME: on vsync blank→active edge (frame start), latch win_*/decim_i, zero row/col/beat counters, increment frame_cnt_o, go to IN_FRAME.
- Window inputs are ignored at all other times.
- FSM IN_FRAME: each cycle with href active, the beat is captured. When beat index = BEATS_PER_PIXEL-1, the pixel completes: col increments (saturating at all-ones) and the beat index clears.
- On href falling edge: row increments (saturating), col and beat clear. If beat index ≠ 0, pulse beat_err_o and discard the partial pixel.
- Frame end: vsync re-enters blank → WAIT_FRAME. If fewer than the window's last row were emitted (win_h_i≠0, win_w_i≠0), pulse trunc_err_o in the same cycle.
- Emit rule for a completed pixel at (col,row): win_x≤col<win_x+win_w, win_y≤row<win_y+win_h, and low decim bits of (col-win_x) and (row-win_y) are zero.
- All comparisons use COORD_WIDTH+1-bit sums so window ends past 2^COORD_WIDTH do not wrap.
- Output coordinates: col_o=(col-win_x)>>decim, row_o=(row-win_y)>>decim.
- eol_o is set when (col-win_x) is the last sampled column < win_w. eof_o is set when eol_o is set and the row is the last sampled row < win_h. sof_o is set when both relative coordinates are 0.
- Latency: pix_valid_o rises 2 pixclk_i cycles after the rising edge that samples the final beat. pix_valid_o is never high for 2 consecutive cycles when BEATS_PER_PIXEL=2.
- Frame-start edge and href active on the same cycle: the frame start takes effect first and the beat counts as row 0.
- href activity during WAIT_FRAME: ignored.
- Window changes mid-frame: no effect until the next frame start.

Decomposition:
- Package camera_pkg: coord_t (COORD_WIDTH logic vector), decim_e enum, capture_state_e {WAIT_FRAME, IN_FRAME}, and constant MAX_BEATS=2.
- Sub-module camera_sync_edge: input register, polarity normalisation, and rise/fall detection of href/vsync. Instantiated once.

Test Plan:
- 8-bit, 1 beat, 6x4 frame, window (1,1,4,2), decim 0 → 8 valid pixels, coords (0..3,0..1), data matches source, sof on (0,0), eol on col 3, eof on (3,1).
- BEATS_PER_PIXEL=2, beats 0xAB,0xCD → pix_o=0xABCD exactly 2 cycles after the 0xCD sample; a 5-beat line → beat_err_o pulses once and 2 pixels are output.
- 16x8 frame, window (0,0,16,8), decim 2 → 4x2 pixels, source cols 0/4/8/12 and rows 0/4, eof on (3,1).
- win_x_i changed from 0 to 2 mid-frame → current frame unchanged, next frame's col_o 0 = source col 2, frame_cnt_o increments by 1 per frame.
- vsync blank after 1 of 4 window rows → trunc_err_o pulse, no eof_o. reset_n_i asserted mid-line → all outputs 0 immediately; no output until the next frame start.
